rob_commit_ctrl: RTL and testbench
==================================

Name: rob_commit_ctrl

Overview:
- Sequences in-order retirement from the reorder buffer head.
- Commits ALU, CMP and load results as soon as the head entry reports done.
- For a store at the head, runs a request/acknowledge handshake with the load/store unit, then retires the entry.
- Sits between the ROB and the LSU, and keeps a retired-instruction counter for performance and debug.

Parameters:
- ROB_IDX_W, 5, width of a ROB index (32 entries).
- CNT_W, 32, width of the retire counter and the stall counter.

Ports:
- clk  input  1  clock
- rst  input  1  reset
- rob_empty  input  1  ROB holds no valid entries
- head_done  input  1  head entry result is complete (ROB commit_ready)
- head_is_st  input  1  head entry is a store whose address/data are resolved
- head_rob_idx  input  ROB_IDX_W  ROB index of the head entry
- hold  input  1  debug/flush hold; blocks the start of any new retirement
- commit  output  1  one-cycle pulse; ROB advances its commit pointer on the next clk edge
- commit_idx  output  ROB_IDX_W  index being retired; valid when commit=1, else 0
- st_req  output  1  request to the LSU to perform the head store
- st_idx  output  ROB_IDX_W  ROB index of the requested store
- st_ack  input  1  LSU has completed the store
- retire_count  output  CNT_W  total retired instructions
- busy  output  1  FSM is not in IDLE

Behaviour:
- Reset: rst is synchronous, active-high, and wins over all other inputs.
  - Sets the state to IDLE.
  - Clears commit, commit_idx, st_req, st_idx, retire_count and busy to 0.
- FSM states: IDLE, ST_REQ, ST_DONE.
- IDLE:
  - The start condition is rob_empty=0, head_done=1 and hold=0.
  - If the start condition holds and head_is_st=0, commit=1 combinationally in the same cycle, with commit_idx=head_rob_idx. The state stays IDLE. Back-to-back commits occur every cycle.
  - If the start condition holds and head_is_st=1, commit=0. On the next edge: state→ST_REQ, st_req←1, st_idx←head_rob_idx.
  - Otherwise commit=0 and the state stays IDLE.
- ST_REQ:
  - st_req is registered and held at 1 with st_idx stable until st_ack=1.
  - On the edge where st_ack=1: st_req←0, state→ST_DONE.
  - hold is ignored here, because a store already requested is non-speculative.
  - st_ack sampled in IDLE or ST_DONE is ignored.
- ST_DONE:
  - commit=1 for exactly one cycle, with commit_idx=st_idx.
  - Next state is IDLE. The next head is evaluated in IDLE on the following cycle, so there is one bubble after every store.
- retire_count increments by 1 on every edge where commit=1. It wraps modulo 2^CNT_W without saturating.
- busy = (state != IDLE).
- Boundary cases:
  - rob_empty=1 overrides head_done=1: no commit and no store request.
  - At most one retirement per cycle.
  - commit is never asserted while st_req=1.
  - rst asserted in ST_REQ drops st_req on the next edge without a commit; the LSU must tolerate an abandoned request.
  - Index wrap-around (31→0) is handled by the ROB; this block only forwards head_rob_idx.

Optional Feature:
- Macro: ROB_COMMIT_STALL_CNT_EN.
- When defined:
  - Adds output stall_count [CNT_W-1:0], reset to 0.
  - stall_count increments on every cycle with rob_empty=0, commit=0 and hold=0.
  - This covers head-not-done cycles, ST_REQ wait cycles and the post-store bubble.
  - It wraps modulo 2^CNT_W.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset then idle:
  - Stimulus: rst=1 for 2 cycles, then rob_empty=1, head_done=1.
  - Required: commit=0, st_req=0, retire_count=0, busy=0 for 10 cycles.
- Back-to-back ALU commits:
  - Stimulus: rob_empty=0, head_done=1, head_is_st=0, head_rob_idx stepping 30,31,0,1 on consecutive cycles.
  - Required: commit=1 in all 4 cycles with commit_idx=30,31,0,1; retire_count=4.
- Store handshake:
  - Stimulus: head_is_st=1 at head_rob_idx=7; st_ack raised 3 cycles after st_req rises.
  - Required: st_req=1 with st_idx=7 for 3 cycles; commit=0 throughout; then commit=1 for one cycle with commit_idx=7; retire_count+1.
- Hold and not-done gating:
  - Stimulus: hold=1 with the head done, then hold=0 with head_done=0 for 4 cycles.
  - Required: commit=0 throughout.
  - With the macro defined: stall_count=4 (hold cycles are not counted).
- Hold during ST_REQ:
  - Stimulus: a store is pending, hold=1 asserted, st_ack arrives.
  - Required: the store still completes and commit pulses once in ST_DONE.
- Reset mid-store and counter wrap:
  - Stimulus: rst in ST_REQ.
  - Required: the next cycle is IDLE with st_req=0 and no commit.
  - Stimulus: preload with CNT_W=4 and 16 commits.
  - Required: retire_count reads 0.

Source files
------------

// File: rtl/rob_commit_if.sv
// Handshake bundle between the ROB/LSU and the commit controller.
// master: the commit controller (drives commit and store request).
// slave:  the ROB/LSU side (drives head status and store acknowledge).
interface rob_commit_if #(
    parameter int ROB_IDX_W = 5
);
    // ROB head status and debug hold
    logic                 rob_empty;
    logic                 head_done;
    logic                 head_is_st;
    logic [ROB_IDX_W-1:0] head_rob_idx;
    logic                 hold;
    // Retirement toward the ROB
    logic                 commit;
    logic [ROB_IDX_W-1:0] commit_idx;
    // Store handshake with the LSU
    logic                 st_req;
    logic [ROB_IDX_W-1:0] st_idx;
    logic                 st_ack;

    modport master (
        input  rob_empty, head_done, head_is_st, head_rob_idx, hold, st_ack,
        output commit, commit_idx, st_req, st_idx
    );

    modport slave (
        output rob_empty, head_done, head_is_st, head_rob_idx, hold, st_ack,
        input  commit, commit_idx, st_req, st_idx
    );
endinterface

// File: rtl/rob_commit_ctrl.sv
// In-order retirement sequencer for the reorder buffer head.
// Non-store results commit combinationally the cycle the head reports done;
// stores go through a req/ack handshake with the LSU, then commit in ST_DONE.
// Optional: define ROB_COMMIT_STALL_CNT_EN to add the stall_count output.
module rob_commit_ctrl #(
    parameter int ROB_IDX_W = 5,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    rob_commit_if.master     bus,
    output logic [CNT_W-1:0] retire_count,
`ifdef ROB_COMMIT_STALL_CNT_EN
    output logic [CNT_W-1:0] stall_count,
`endif
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t               state;
    state_t               next_state;
    logic                 start;
    logic                 st_req_q;
    logic [ROB_IDX_W-1:0] st_idx_q;

    // Head may begin retiring: valid, complete, and not held.
    assign start = !bus.rob_empty && bus.head_done && !bus.hold;

    // State register and registered store request.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values, independent of block ordering.
        if (rst) begin
            state    <= IDLE;
            st_req_q <= 1'b0;
        end else begin
            state    <= next_state;
            st_req_q <= (next_state == ST_REQ);
        end
    end

    // Next-state logic; hold only gates the start of a retirement.
    always_comb begin
        // NOTE: default first so every path assigns and no latch is inferred.
        next_state = state;
        case (state)
            IDLE:    if (start && bus.head_is_st) next_state = ST_REQ;
            ST_REQ:  if (bus.st_ack)              next_state = ST_DONE;
            ST_DONE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Output decode: commit pulse and its index; reset suppresses a commit.
    always_comb begin
        bus.commit     = 1'b0;
        bus.commit_idx = '0;
        case (state)
            IDLE: begin
                if (start && !bus.head_is_st) begin
                    bus.commit     = 1'b1;
                    bus.commit_idx = bus.head_rob_idx;
                end
            end
            ST_DONE: begin
                bus.commit     = 1'b1;
                bus.commit_idx = st_idx_q;
            end
            default: ;
        endcase
        if (rst) begin
            bus.commit     = 1'b0;
            bus.commit_idx = '0;
        end
    end

    // Capture the store's index when the request is launched from IDLE.
    always_ff @(posedge clk) begin
        if (rst)
            st_idx_q <= '0;
        else if (state == IDLE && start && bus.head_is_st)
            st_idx_q <= bus.head_rob_idx;
    end

    // Retired-instruction counter, wrapping modulo 2^CNT_W.
    always_ff @(posedge clk) begin
        if (rst)
            retire_count <= '0;
        else if (bus.commit)
            retire_count <= retire_count + 1'b1;
    end

`ifdef ROB_COMMIT_STALL_CNT_EN
    // Stall counter: cycles with work at the head that neither retire nor are held.
    always_ff @(posedge clk) begin
        if (rst)
            stall_count <= '0;
        else if (!bus.rob_empty && !bus.commit && !bus.hold)
            stall_count <= stall_count + 1'b1;
    end
`endif

    assign bus.st_req = st_req_q;
    assign bus.st_idx = st_idx_q;
    assign busy       = (state != IDLE);

endmodule

// File: tb/tb_rob_commit_ctrl.sv
// Self-checking bench for rob_commit_ctrl: directed scenarios followed by
// random stimulus, compared against a behavioural retirement model.
// A second instance with CNT_W=4 shadows the same stimulus to show wrap-around.
module tb_rob_commit_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rob_commit_if #(.ROB_IDX_W(5)) bus ();
    rob_commit_if #(.ROB_IDX_W(5)) bus_w ();

    logic [31:0] retire_count;
    logic [3:0]  retire_w;
    logic        busy;
    logic        busy_w;
`ifdef ROB_COMMIT_STALL_CNT_EN
    logic [31:0] stall_count;
    logic [3:0]  stall_w;
`endif

    rob_commit_ctrl #(.ROB_IDX_W(5), .CNT_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus.master),
        .retire_count (retire_count),
`ifdef ROB_COMMIT_STALL_CNT_EN
        .stall_count  (stall_count),
`endif
        .busy         (busy)
    );

    rob_commit_ctrl #(.ROB_IDX_W(5), .CNT_W(4)) dut_w (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus_w.master),
        .retire_count (retire_w),
`ifdef ROB_COMMIT_STALL_CNT_EN
        .stall_count  (stall_w),
`endif
        .busy         (busy_w)
    );

    assign bus_w.rob_empty    = bus.rob_empty;
    assign bus_w.head_done    = bus.head_done;
    assign bus_w.head_is_st   = bus.head_is_st;
    assign bus_w.head_rob_idx = bus.head_rob_idx;
    assign bus_w.hold         = bus.hold;
    assign bus_w.st_ack       = bus.st_ack;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: a store is either waiting for ack, or acked and
    // retiring this cycle; otherwise the head may retire directly.
    bit          m_pend = 1'b0;
    bit          m_done = 1'b0;
    logic [4:0]  m_idx  = '0;
    logic [31:0] m_ret  = '0;
    logic [31:0] m_stall = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive at negedge, compare after settling, advance model at posedge.
    task automatic step(input logic r, input logic re, input logic hd, input logic st,
                        input logic [4:0] idx, input logic h, input logic ack);
        logic       start;
        logic       e_commit;
        logic [4:0] e_cidx;
        @(negedge clk);
        rst              = r;
        bus.rob_empty    = re;
        bus.head_done    = hd;
        bus.head_is_st   = st;
        bus.head_rob_idx = idx;
        bus.hold         = h;
        bus.st_ack       = ack;
        #1;
        start    = !re && hd && !h;
        e_commit = r ? 1'b0 : (m_done ? 1'b1 : (!m_pend && start && !st));
        e_cidx   = !e_commit ? 5'd0 : (m_done ? m_idx : idx);
        chk("commit",       {31'd0, bus.commit},  {31'd0, e_commit});
        chk("commit_idx",   {27'd0, bus.commit_idx}, {27'd0, e_cidx});
        chk("st_req",       {31'd0, bus.st_req},  {31'd0, m_pend});
        chk("st_idx",       {27'd0, bus.st_idx},  {27'd0, m_idx});
        chk("busy",         {31'd0, busy},        {31'd0, (m_pend || m_done)});
        chk("retire_count", retire_count,         m_ret);
        chk("retire_w",     {28'd0, retire_w},    {28'd0, m_ret[3:0]});
        chk("commit_vs_req", {31'd0, (bus.commit && bus.st_req)}, 32'd0);
`ifdef ROB_COMMIT_STALL_CNT_EN
        chk("stall_count",  stall_count,          m_stall);
        chk("stall_w",      {28'd0, stall_w},     {28'd0, m_stall[3:0]});
`endif
        @(posedge clk);
        if (r) begin
            m_pend  = 1'b0;
            m_done  = 1'b0;
            m_idx   = '0;
            m_ret   = '0;
            m_stall = '0;
        end else begin
            if (e_commit) m_ret = m_ret + 1;
            if (!re && !e_commit && !h) m_stall = m_stall + 1;
            if (m_done) begin
                m_done = 1'b0;
            end else if (m_pend) begin
                if (ack) begin
                    m_pend = 1'b0;
                    m_done = 1'b1;
                end
            end else if (start && st) begin
                m_pend = 1'b1;
                m_idx  = idx;
            end
        end
    endtask

    initial begin
        bus.rob_empty    = 1'b1;
        bus.head_done    = 1'b0;
        bus.head_is_st   = 1'b0;
        bus.head_rob_idx = '0;
        bus.hold         = 1'b0;
        bus.st_ack       = 1'b0;

        // Reset, then an empty ROB that claims done must stay idle.
        step(1, 1, 1, 0, 5'd0, 0, 0);
        step(1, 1, 1, 0, 5'd0, 0, 0);
        for (int i = 0; i < 10; i++) step(0, 1, 1, 0, 5'(i), 0, 0);

        // Back-to-back ALU commits across the index wrap.
        step(0, 0, 1, 0, 5'd30, 0, 0);
        step(0, 0, 1, 0, 5'd31, 0, 0);
        step(0, 0, 1, 0, 5'd0,  0, 0);
        step(0, 0, 1, 0, 5'd1,  0, 0);
        #1 chk("retire_after_b2b", retire_count, 32'd4);

        // Store at index 7, ack on the third request cycle, then the bubble.
        step(0, 0, 1, 1, 5'd7, 0, 0);
        step(0, 0, 1, 1, 5'd7, 0, 0);
        step(0, 0, 1, 1, 5'd7, 0, 0);
        step(0, 0, 1, 1, 5'd7, 0, 1);
        step(0, 0, 1, 1, 5'd7, 0, 0);
        step(0, 0, 0, 0, 5'd8, 0, 0);
        #1 chk("retire_after_store", retire_count, 32'd5);

        // Hold with head done, then head not done for four cycles.
        step(1, 1, 0, 0, 5'd0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 5'd9, 1, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 5'd9, 0, 0);
        #1 chk("retire_after_hold", retire_count, 32'd0);
`ifdef ROB_COMMIT_STALL_CNT_EN
        chk("stall_after_hold", stall_count, 32'd4);
`endif

        // Hold raised while the store is pending: the store still retires once.
        step(0, 0, 1, 1, 5'd12, 0, 0);
        step(0, 0, 1, 1, 5'd12, 1, 0);
        step(0, 0, 1, 1, 5'd12, 1, 1);
        step(0, 0, 1, 1, 5'd12, 1, 0);
        step(0, 0, 1, 1, 5'd12, 1, 0);
        #1 chk("retire_after_hold_st", retire_count, 32'd1);

        // Reset while a store is requested: abandoned without a commit.
        step(0, 0, 1, 1, 5'd3, 0, 0);
        step(0, 0, 1, 1, 5'd3, 0, 0);
        step(1, 0, 1, 1, 5'd3, 0, 1);
        step(0, 1, 0, 0, 5'd3, 0, 0);
        #1 chk("retire_after_rst_st", retire_count, 32'd0);

        // Sixteen commits wrap the 4-bit counter to zero.
        step(1, 1, 0, 0, 5'd0, 0, 0);
        for (int i = 0; i < 16; i++) step(0, 0, 1, 0, 5'(i), 0, 0);
        #1 chk("retire_w_wrap", {28'd0, retire_w}, 32'd0);
        chk("retire_16", retire_count, 32'd16);

        // Random traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            step(($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 2) == 0),
                 5'($urandom_range(0, 31)),
                 ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 2) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
